// File: rtl/font_pixel_reader_if.sv
// Pixel-stream bus for the font read stage: pixel timing and character code in,
// font ROM address/data exchange, and the coloured pixel out.
interface font_pixel_reader_if;
  logic        pixel_tick;
  logic        video_on;
  logic [9:0]  pixel_x;
  logic [9:0]  pixel_y;
  logic [6:0]  char_code;
  logic [10:0] rom_addr;
  logic [7:0]  rom_data;
  logic [11:0] rgb;
  logic        pix_valid;
  logic        overrun;

  modport master (
    output pixel_tick, video_on, pixel_x, pixel_y, char_code, rom_data,
    input  rom_addr, rgb, pix_valid, overrun
  );

  modport slave (
    input  pixel_tick, video_on, pixel_x, pixel_y, char_code, rom_data,
    output rom_addr, rgb, pix_valid, overrun
  );
endinterface

// File: rtl/font_pixel_reader.sv
// Two-stage text pixel pipeline: each pixel_tick issues a font ROM fetch for the new
// pixel and serializes the previously fetched glyph row into an RGB pixel.
module font_pixel_reader #(
  parameter int          ROM_LAT  = 1,        // 1..3 clocks from address to data
  parameter logic [11:0] FG_COLOR = 12'hFFF,
  parameter logic [11:0] BG_COLOR = 12'h000
) (
  input  logic               clk,
  input  logic               rst_n,
  font_pixel_reader_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WAIT, CAPTURE} state_t;

  localparam logic [1:0] LAT_CNT = 2'(ROM_LAT);

  state_t      state_reg, state_next;
  logic [1:0]  wait_cnt_reg, wait_cnt_next;
  logic        capture;
  logic [7:0]  glyph_reg;
  logic [2:0]  col_a_reg;
  logic        von_a_reg;
  logic [10:0] rom_addr_reg;
  logic [11:0] rgb_reg;
  logic        pix_valid_reg;
  logic        overrun_reg;

  // Only the position within an 8x16 cell matters.
  wire unused_bits = &{1'b0, bus.pixel_x[9:3], bus.pixel_y[9:4]};

  // A new tick always restarts the fetch, even over a pending capture.
  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    capture       = 1'b0;
    if (bus.pixel_tick) begin
      state_next    = WAIT;
      wait_cnt_next = LAT_CNT;
    end else begin
      case (state_reg)
        WAIT: begin
          wait_cnt_next = wait_cnt_reg - 2'd1;
          if (wait_cnt_reg <= 2'd1) state_next = CAPTURE;
        end
        CAPTURE: begin
          capture    = 1'b1;
          state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      wait_cnt_reg  <= 2'd0;
      glyph_reg     <= 8'd0;
      col_a_reg     <= 3'd0;
      von_a_reg     <= 1'b0;
      rom_addr_reg  <= 11'd0;
      rgb_reg       <= 12'd0;
      pix_valid_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      if (capture) glyph_reg <= bus.rom_data;
      if (bus.pixel_tick) begin
        rom_addr_reg <= {bus.char_code, bus.pixel_y[3:0]};
        col_a_reg    <= bus.pixel_x[2:0];
        von_a_reg    <= bus.video_on;
        // Stage B sees glyph_reg as it was before this edge, stale if a fetch was cut short.
        if (von_a_reg) begin
          rgb_reg       <= glyph_reg[3'd7 - col_a_reg] ? FG_COLOR : BG_COLOR;
          pix_valid_reg <= 1'b1;
        end else begin
          rgb_reg       <= 12'd0;
          pix_valid_reg <= 1'b0;
        end
        if (state_reg != IDLE) overrun_reg <= 1'b1;
      end
    end
  end

  assign bus.rom_addr  = rom_addr_reg;
  assign bus.rgb       = rgb_reg;
  assign bus.pix_valid = pix_valid_reg;
  assign bus.overrun   = overrun_reg;

endmodule

// File: tb/tb_font_pixel_reader.sv
// Directed bench: three readers (ROM_LAT 1,2,3) share one pixel stream, each
// with a behavioural font ROM of matching latency.
module tb_font_pixel_reader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pixel_tick = 1'b0;
  logic       video_on = 1'b0;
  logic [9:0] pixel_x = '0;
  logic [9:0] pixel_y = '0;
  logic [6:0] char_code = '0;

  logic [2:0][11:0] rgb_o;
  logic [2:0][10:0] addr_o;
  logic [2:0]       pv_o;
  logic [2:0]       ov_o;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  function automatic logic [7:0] font(input logic [10:0] a);
    case (a)
      11'h453: return 8'hA1;
      11'h4A0: return 8'hC9;
      11'h000: return 8'h3C;
      default: return 8'h5A;
    endcase
  endfunction

  for (genvar gi = 0; gi < 3; gi++) begin : g_lat
    font_pixel_reader_if bus();
    logic [10:0] d1, d2, d3;

    assign bus.pixel_tick = pixel_tick;
    assign bus.video_on   = video_on;
    assign bus.pixel_x    = pixel_x;
    assign bus.pixel_y    = pixel_y;
    assign bus.char_code  = char_code;

    // Data for an address is valid exactly gi+1 clocks after the address changes.
    always @(posedge clk) begin
      d1 <= bus.rom_addr;
      d2 <= d1;
      d3 <= d2;
    end
    assign bus.rom_data = font((gi == 0) ? d1 : (gi == 1) ? d2 : d3);

    font_pixel_reader #(.ROM_LAT(gi + 1)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
    );

    assign rgb_o[gi]  = bus.rgb;
    assign addr_o[gi] = bus.rom_addr;
    assign pv_o[gi]   = bus.pix_valid;
    assign ov_o[gi]   = bus.overrun;
  end

  // Called #1 after a rising edge; the tick lands on the next edge, and the task
  // returns #1 after the edge sp clocks later minus one, so ticks are sp clocks apart.
  task automatic do_tick(input logic [9:0] x, input logic [9:0] y, input logic [6:0] cc,
                         input logic von, input int sp);
    pixel_x = x; pixel_y = y; char_code = cc; video_on = von; pixel_tick = 1'b1;
    @(posedge clk); #1;
    pixel_tick = 1'b0;
    repeat (sp - 1) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++; if (rgb_o[0] !== 12'h000) $display("FAIL por_rgb: got %h want 000", rgb_o[0]); else pass_cnt++;
    total_cnt++; if (pv_o[0] !== 1'b0) $display("FAIL por_pix_valid: got %b want 0", pv_o[0]); else pass_cnt++;
    total_cnt++; if (addr_o[0] !== 11'h000) $display("FAIL por_rom_addr: got %h want 000", addr_o[0]); else pass_cnt++;
    total_cnt++; if (ov_o[0] !== 1'b0) $display("FAIL por_overrun: got %b want 0", ov_o[0]); else pass_cnt++;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    do_tick(10'd0, 10'd3, 7'h45, 1'b1, 4);
    do_tick(10'd1, 10'd3, 7'h45, 1'b1, 2);
    do_tick(10'd2, 10'd3, 7'h45, 1'b1, 4);
    total_cnt++; if (pv_o[0] !== 1'b1) $display("FAIL pre_rst_pix_valid: got %b want 1", pv_o[0]); else pass_cnt++;
    total_cnt++; if (ov_o[0] !== 1'b1) $display("FAIL pre_rst_overrun: got %b want 1", ov_o[0]); else pass_cnt++;
    #3 rst_n = 1'b0;
    #1;
    total_cnt++; if (rgb_o[0] !== 12'h000) $display("FAIL rst_rgb: got %h want 000", rgb_o[0]); else pass_cnt++;
    total_cnt++; if (pv_o[0] !== 1'b0) $display("FAIL rst_pix_valid: got %b want 0", pv_o[0]); else pass_cnt++;
    total_cnt++; if (addr_o[0] !== 11'h000) $display("FAIL rst_rom_addr: got %h want 000", addr_o[0]); else pass_cnt++;
    total_cnt++; if (ov_o[0] !== 1'b0) $display("FAIL rst_overrun: got %b want 0", ov_o[0]); else pass_cnt++;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    do_tick(10'd3, 10'd3, 7'h45, 1'b1, 4);
    total_cnt++; if (pv_o[0] !== 1'b0) $display("FAIL post_rst_tick1_pix_valid: got %b want 0", pv_o[0]); else pass_cnt++;
    do_tick(10'd4, 10'd3, 7'h45, 1'b1, 4);
    total_cnt++; if (pv_o[0] !== 1'b1) $display("FAIL post_rst_tick2_pix_valid: got %b want 1", pv_o[0]); else pass_cnt++;
    total_cnt++; if (rgb_o[0] !== 12'h000) $display("FAIL post_rst_tick2_rgb: got %h want 000", rgb_o[0]); else pass_cnt++;
    total_cnt++; if (ov_o[0] !== 1'b0) $display("FAIL post_rst_overrun: got %b want 0", ov_o[0]); else pass_cnt++;
  endtask

  task automatic test_serialize;
    // Glyph 8'b1010_0001, leftmost pixel first.
    logic [11:0] exp_rgb [8] = '{12'hFFF, 12'h000, 12'hFFF, 12'h000,
                                 12'h000, 12'h000, 12'h000, 12'hFFF};
    for (int i = 0; i <= 8; i++) begin
      do_tick(10'(i), 10'd3, 7'h45, 1'b1, 4);
      total_cnt++; if (addr_o[0] !== 11'h453) $display("FAIL ser_rom_addr x=%0d: got %h want 453", i, addr_o[0]); else pass_cnt++;
      if (i > 0) begin
        total_cnt++; if (rgb_o[0] !== exp_rgb[i-1]) $display("FAIL ser_rgb x=%0d: got %h want %h", i - 1, rgb_o[0], exp_rgb[i-1]); else pass_cnt++;
        total_cnt++; if (pv_o[0] !== 1'b1) $display("FAIL ser_pix_valid x=%0d: got %b want 1", i - 1, pv_o[0]); else pass_cnt++;
      end
    end
  endtask

  task automatic test_blanking;
    for (int k = 640; k <= 645; k++) begin
      do_tick(10'(k), 10'd5, 7'(k), 1'b0, 4);
      total_cnt++; if (addr_o[0] !== {7'(k), 4'h5}) $display("FAIL blank_rom_addr x=%0d: got %h want %h", k, addr_o[0], {7'(k), 4'h5}); else pass_cnt++;
      if (k == 640) begin
        total_cnt++; if (rgb_o[0] !== 12'hFFF || pv_o[0] !== 1'b1) $display("FAIL blank_edge_last_active: got %h/%b want FFF/1", rgb_o[0], pv_o[0]); else pass_cnt++;
      end else begin
        total_cnt++; if (rgb_o[0] !== 12'h000) $display("FAIL blank_rgb x=%0d: got %h want 000", k - 1, rgb_o[0]); else pass_cnt++;
        total_cnt++; if (pv_o[0] !== 1'b0) $display("FAIL blank_pix_valid x=%0d: got %b want 0", k - 1, pv_o[0]); else pass_cnt++;
      end
    end
  endtask

  task automatic test_char_change;
    // Pixels 0..3 from 8'h3C, pixels 4..7 from 8'hC9.
    logic [11:0] exp_rgb [8] = '{12'h000, 12'h000, 12'hFFF, 12'hFFF,
                                 12'hFFF, 12'h000, 12'h000, 12'hFFF};
    for (int i = 0; i <= 8; i++) begin
      logic [6:0]  cc;
      logic [10:0] ea;
      cc = (i < 4) ? 7'h00 : 7'h4A;
      ea = (i < 4) ? 11'h000 : 11'h4A0;
      do_tick(10'(i), 10'd0, cc, 1'b1, 4);
      total_cnt++; if (addr_o[0] !== ea) $display("FAIL chg_rom_addr x=%0d: got %h want %h", i, addr_o[0], ea); else pass_cnt++;
      if (i == 0) begin
        total_cnt++; if (pv_o[0] !== 1'b0) $display("FAIL chg_blank_tail_pix_valid: got %b want 0", pv_o[0]); else pass_cnt++;
      end else begin
        total_cnt++; if (rgb_o[0] !== exp_rgb[i-1]) $display("FAIL chg_rgb x=%0d: got %h want %h", i - 1, rgb_o[0], exp_rgb[i-1]); else pass_cnt++;
      end
    end
  endtask

  task automatic test_overrun;
    total_cnt++; if (ov_o[0] !== 1'b0) $display("FAIL ovr_initial: got %b want 0", ov_o[0]); else pass_cnt++;
    do_tick(10'd6, 10'd0, 7'h4A, 1'b1, 3);
    do_tick(10'd7, 10'd0, 7'h4A, 1'b1, 3);
    total_cnt++; if (ov_o[0] !== 1'b0) $display("FAIL ovr_spacing3: got %b want 0", ov_o[0]); else pass_cnt++;
    total_cnt++; if (rgb_o[0] !== 12'h000) $display("FAIL ovr_spacing3_rgb: got %h want 000", rgb_o[0]); else pass_cnt++;
    do_tick(10'd1, 10'd3, 7'h45, 1'b1, 2);
    total_cnt++; if (rgb_o[0] !== 12'hFFF) $display("FAIL ovr_pre_rgb: got %h want FFF", rgb_o[0]); else pass_cnt++;
    total_cnt++; if (ov_o[0] !== 1'b0) $display("FAIL ovr_pre_flag: got %b want 0", ov_o[0]); else pass_cnt++;
    do_tick(10'd2, 10'd3, 7'h45, 1'b1, 4);
    total_cnt++; if (ov_o[0] !== 1'b1) $display("FAIL ovr_set: got %b want 1", ov_o[0]); else pass_cnt++;
    total_cnt++; if (rgb_o[0] !== 12'hFFF) $display("FAIL ovr_stale_rgb: got %h want FFF", rgb_o[0]); else pass_cnt++;
    do_tick(10'd3, 10'd3, 7'h45, 1'b1, 4);
    total_cnt++; if (rgb_o[0] !== 12'hFFF) $display("FAIL ovr_recover_rgb_x2: got %h want FFF", rgb_o[0]); else pass_cnt++;
    do_tick(10'd4, 10'd3, 7'h45, 1'b1, 4);
    total_cnt++; if (rgb_o[0] !== 12'h000) $display("FAIL ovr_recover_rgb_x3: got %h want 000", rgb_o[0]); else pass_cnt++;
    total_cnt++; if (ov_o[0] !== 1'b1) $display("FAIL ovr_sticky: got %b want 1", ov_o[0]); else pass_cnt++;
  endtask

  task automatic test_latency_sweep;
    // Even columns fetch 8'hA1 (addr 453), odd columns 8'hC9 (addr 4A0).
    logic [11:0] exp_rgb [8] = '{12'hFFF, 12'hFFF, 12'hFFF, 12'h000,
                                 12'h000, 12'h000, 12'h000, 12'hFFF};
    #3 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i <= 8; i++) begin
      if (i % 2 == 0) do_tick(10'(i), 10'd3, 7'h45, 1'b1, 4);
      else            do_tick(10'(i), 10'd0, 7'h4A, 1'b1, 4);
      if (i > 0) begin
        total_cnt++; if (rgb_o[0] !== exp_rgb[i-1]) $display("FAIL lat1_rgb x=%0d: got %h want %h", i - 1, rgb_o[0], exp_rgb[i-1]); else pass_cnt++;
        total_cnt++; if (rgb_o[1] !== exp_rgb[i-1]) $display("FAIL lat2_rgb x=%0d: got %h want %h", i - 1, rgb_o[1], exp_rgb[i-1]); else pass_cnt++;
      end
      if (i == 0 || i == 8) begin
        total_cnt++; if (ov_o[0] !== 1'b0) $display("FAIL lat1_overrun i=%0d: got %b want 0", i, ov_o[0]); else pass_cnt++;
        total_cnt++; if (ov_o[1] !== 1'b0) $display("FAIL lat2_overrun i=%0d: got %b want 0", i, ov_o[1]); else pass_cnt++;
      end
      if (i == 0) begin
        total_cnt++; if (ov_o[2] !== 1'b0) $display("FAIL lat3_overrun_first: got %b want 0", ov_o[2]); else pass_cnt++;
      end
      if (i == 1 || i == 8) begin
        total_cnt++; if (ov_o[2] !== 1'b1) $display("FAIL lat3_overrun i=%0d: got %b want 1", i, ov_o[2]); else pass_cnt++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_serialize();
    test_blanking();
    test_char_change();
    test_overrun();
    test_latency_sweep();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
